channel_event_scheduler: RTL and testbench
==========================================

CHANNEL_EVENT_SCHEDULER -- requirements
Module: channel_event_scheduler

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp/timer width in bits.
REQ-002 SHALL have port clk  input  1  500 MHz system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port pulse  input  4  shaped photon pulses, one per channel, from the per-channel pulse shapers.
REQ-005 SHALL have port run_start  input  1  single-cycle request to begin a measurement run.
REQ-006 SHALL have port run_stop  input  1  single-cycle request to end the run early.
REQ-007 SHALL have port window_len  input  TS_W  run length in cycles; 0 means unbounded, ended by run_stop only.
REQ-008 SHALL have port evt_valid  output  1  event output valid.
REQ-009 SHALL have port evt_ready  input  1  downstream accepts the event.
REQ-010 SHALL have port evt_ch  output  2  channel index of the event.
REQ-011 SHALL have port evt_time  output  TS_W  run-relative timestamp of the event.
REQ-012 SHALL have port run_active  output  1  high in states RUN and DRAIN.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the run completes.
REQ-014 SHALL have port drop_count  output  8  events lost because the channel was already pending.

Function
REQ-015 SHALL implement FSM IDLE/RUN/DRAIN: IDLE->RUN on run_start; RUN->DRAIN on run_stop, or on timer==window_len-1 with window_len!=0; DRAIN->IDLE when no event is pending and evt_valid is low, asserting done for exactly that transition cycle.
REQ-016 SHALL clear the timer to 0 on IDLE->RUN and increment it by 1 every RUN cycle, wrapping modulo 2^TS_W.
REQ-017 SHALL detect a rising edge on pulse[i] as pulse[i]=1 with its previous-cycle sample 0; edges are accepted only in RUN, including the final RUN cycle.
REQ-018 SHALL, on an accepted edge, set pending[i] and latch the timer value of that same cycle as the channel timestamp.
REQ-019 SHALL, on an edge while pending[i] is already set and not being granted that cycle, keep the old timestamp and increment drop_count, saturating at 255.
REQ-020 SHALL, when pending[i] is granted in the same cycle as a new edge on i, accept the new edge: pending stays set with the new timestamp and no drop is counted.
REQ-021 SHALL grant round-robin among pending channels whenever the output register is empty or being accepted (evt_valid & evt_ready); priority starts at the channel after the last granted one; the pointer is 0 after reset.
REQ-022 SHALL load evt_ch/evt_time from the granted channel and clear its pending bit in the grant cycle; evt_valid is set on the following edge.
REQ-023 SHALL give a latency of 2 cycles from the first high sample of pulse to evt_valid, with the output empty and no competing pending channel.
REQ-024 SHALL hold evt_valid, evt_ch and evt_time stable while evt_valid=1 and evt_ready=0.
REQ-025 SHALL support back-to-back events, one per cycle, while evt_ready=1.
REQ-026 SHALL ignore run_start in RUN/DRAIN, ignore run_stop in IDLE/DRAIN, and treat run_start and run_stop together in IDLE as start.
REQ-027 SHALL clear drop_count on IDLE->RUN.

Reset
REQ-028 SHALL on rst=1 force: state IDLE, timer 0, pending 0, previous-pulse samples 0, round-robin pointer 0, evt_valid 0, evt_ch 0, evt_time 0, run_active 0, done 0, drop_count 0.
REQ-029 SHALL discard any in-flight run and queued events when rst is asserted mid-run; no done pulse is issued.

Configuration
REQ-030 SHALL, when macro SCHED_DROP_COUNT_EN is defined, implement drop counting per REQ-019/REQ-027; when it is undefined, drop_count SHALL be constant 0, the counter SHALL be omitted, and all other behaviour SHALL be unchanged.

Verification
REQ-031 SHALL verify: window_len=100, run_start, pulse[2] rises at timer 5 -> evt_valid 2 cycles later, evt_ch=2, evt_time=5; done 1 cycle after DRAIN empties, following timer 99.
REQ-032 SHALL verify: pulse=4'b1111 rising together, evt_ready=1, pointer 0 -> events ch0,ch1,ch2,ch3 on consecutive cycles, all with the same evt_time.
REQ-033 SHALL verify: evt_ready=0 for 10 cycles with ch1 pending and ch1 edges every 3 cycles -> output stable, drop_count=2 (with SCHED_DROP_COUNT_EN), 0 without.
REQ-034 SHALL verify: window_len=0, run for 70000 cycles, then run_stop -> timestamps wrap past 65535 to 0; DRAIN flushes pending; done once.
REQ-035 SHALL verify: rst asserted with 3 events pending and evt_valid=1 -> next cycle all outputs at reset values, no done; a new run_start operates normally.

Source files
------------

// File: rtl/channel_event_scheduler.sv
// Four-channel photon event scheduler: edge capture with per-channel timestamps, round-robin
// drain into a valid/ready output register. Optional drop counter: define SCHED_DROP_COUNT_EN.
module channel_event_scheduler #(
  parameter int TS_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      pulse,
  input  logic            run_start,
  input  logic            run_stop,
  input  logic [TS_W-1:0] window_len,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_ch,
  output logic [TS_W-1:0] evt_time,
  output logic            run_active,
  output logic            done,
  output logic [7:0]      drop_count,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TS_W-1:0] timer_q, timer_d;
  logic [3:0]      pulse_prev_q, pulse_prev_d;
  logic [3:0]      pending_q, pending_d;
  logic [TS_W-1:0] ts_q [4];
  logic [TS_W-1:0] ts_d [4];
  logic [1:0]      rr_q, rr_d;
  logic            evt_valid_q, evt_valid_d;
  logic [1:0]      evt_ch_q, evt_ch_d;
  logic [TS_W-1:0] evt_time_q, evt_time_d;

  logic [3:0] pulse_edge;
  logic       in_run;
  logic       start_run;
  logic       last_cycle;
  logic       drain_empty;
  logic       can_load;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] rr_probe;

`ifdef SCHED_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;
  logic [2:0] drop_num;
  logic [8:0] drop_sum;
`endif

  // Handshake: an event transfers on a rising clk edge where evt_valid & evt_ready; while
  // evt_valid is high and evt_ready low the output register holds ch/time unchanged.
  always_comb begin
    pulse_edge  = pulse & ~pulse_prev_q;
    in_run      = (state_q == ST_RUN);
    start_run   = (state_q == ST_IDLE) && run_start;
    last_cycle  = (window_len != '0) && (timer_q == window_len - TS_W'(1));
    drain_empty = (pending_q == 4'b0000) && !evt_valid_q;
    can_load    = !evt_valid_q || evt_ready;
    gnt_valid   = can_load && (pending_q != 4'b0000);
  end

  // Round-robin pick: scan from rr_q upward; the highest k is tested first so the
  // channel closest to rr_q overwrites and wins.
  always_comb begin
    gnt_idx  = rr_q;
    rr_probe = rr_q;
    for (int k = 3; k >= 0; k--) begin
      rr_probe = rr_q + 2'(k);
      if (pending_q[rr_probe]) gnt_idx = rr_probe;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (run_start) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        timer_d = timer_q + TS_W'(1);
        if (run_stop || last_cycle) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_prev_d = pulse;
    pending_d    = pending_q;
    for (int i = 0; i < 4; i++) begin
      ts_d[i] = ts_q[i];
      if (gnt_valid && (gnt_idx == 2'(i))) pending_d[i] = 1'b0;
      // A granted channel frees its slot this cycle, so a coincident edge is kept.
      if (in_run && pulse_edge[i] && (!pending_q[i] || (gnt_valid && (gnt_idx == 2'(i))))) begin
        pending_d[i] = 1'b1;
        ts_d[i]      = timer_q;
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_time_d  = evt_time_q;
    rr_d        = rr_q;
    if (gnt_valid) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = gnt_idx;
      evt_time_d  = ts_q[gnt_idx];
      rr_d        = gnt_idx + 2'd1;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

`ifdef SCHED_DROP_COUNT_EN
  always_comb begin
    drop_num = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (in_run && pulse_edge[i] && pending_q[i] && !(gnt_valid && (gnt_idx == 2'(i))))
        drop_num = drop_num + 3'd1;
    end
    drop_sum = {1'b0, drop_q} + {6'd0, drop_num};
    drop_d   = drop_q;
    if (start_run)              drop_d = 8'd0;
    else if (drop_sum > 9'd255) drop_d = 8'd255;
    else                        drop_d = drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      pulse_prev_q <= 4'b0000;
      pending_q    <= 4'b0000;
      rr_q         <= 2'd0;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= 2'd0;
      evt_time_q   <= '0;
      for (int i = 0; i < 4; i++) ts_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pulse_prev_q <= pulse_prev_d;
      pending_q    <= pending_d;
      rr_q         <= rr_d;
      evt_valid_q  <= evt_valid_d;
      evt_ch_q     <= evt_ch_d;
      evt_time_q   <= evt_time_d;
      for (int i = 0; i < 4; i++) ts_q[i] <= ts_d[i];
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_ch     = evt_ch_q;
  assign evt_time   = evt_time_q;
  assign run_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // Reset discards an in-flight run, so a drain that happens to be empty must not signal done.
  assign done       = (state_q == ST_DRAIN) && drain_empty && !rst;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_channel_event_scheduler.sv
// Directed bench for channel_event_scheduler: scoreboard of {ch,time} events plus
// point checks on latency, hold, drop counting, timer wrap, drain/done and reset.
`timescale 1ns/1ps
module tb_channel_event_scheduler;

  localparam int TS_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      pulse = 4'b0000;
  logic            run_start = 1'b0;
  logic            run_stop = 1'b0;
  logic [TS_W-1:0] window_len = '0;
  logic            evt_valid;
  logic            evt_ready = 1'b1;
  logic [1:0]      evt_ch;
  logic [TS_W-1:0] evt_time;
  logic            run_active;
  logic            done;
  logic [7:0]      drop_count;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad = 0;
  int tmr = 0;
  int done_cnt = 0;
  int exp_drop;
  int saved_done;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  channel_event_scheduler #(.TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .run_start(run_start), .run_stop(run_stop),
    .window_len(window_len), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_time(evt_time), .run_active(run_active), .done(done), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    tmr++;
  endtask

  task automatic step_to(input int t);
    while (tmr < t) step();
  endtask

  task automatic start_run(input logic [TS_W-1:0] wl);
    window_len = wl;
    run_start  = 1'b1;
    step();
    run_start  = 1'b0;
    tmr        = 0;
  endtask

  task automatic fire(input logic [3:0] m, input bit push);
    logic [15:0] t16;
    t16   = tmr[15:0];
    pulse = m;
    if (push) begin
      for (int c = 0; c < 4; c++)
        if (m[c]) exp_q.push_back({2'(c), t16});
    end
    step();
    pulse = 4'b0000;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < limit) begin
      step();
      n++;
    end
    step();
    step();
    chk(tag, 32'(done_cnt - start_cnt), 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && evt_valid && evt_ready) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL evt_unexpected: observed ch=%0d time=%0d expected none", evt_ch, evt_time);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("evt_out", {14'd0, evt_ch, evt_time}, {14'd0, mon_e});
      end
    end
  end

  initial begin
`ifdef SCHED_DROP_COUNT_EN
    exp_drop = 2;
`else
    exp_drop = 0;
`endif
    // reset state
    repeat (3) step();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_time", 32'(evt_time), 32'd0);
    chk("rst_active", 32'(run_active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // run A: window 100, single ch2 event at timer 5, then timed drain
    start_run(16'd100);
    chk("a_active", 32'(run_active), 32'd1);
    step_to(5);
    fire(4'b0100, 1'b1);
    chk("a_lat1_valid", 32'(evt_valid), 32'd0);
    step();
    chk("a_lat2_valid", 32'(evt_valid), 32'd1);
    chk("a_ch", 32'(evt_ch), 32'd2);
    chk("a_time", 32'(evt_time), 32'd5);
    step_to(99);
    chk("a_t99_done", 32'(done), 32'd0);
    chk("a_t99_active", 32'(run_active), 32'd1);
    step();
    chk("a_drain_done", 32'(done), 32'd1);
    chk("a_drain_state", 32'(dbg_state), 32'd2);
    step();
    chk("a_idle_done", 32'(done), 32'd0);
    chk("a_idle_active", 32'(run_active), 32'd0);
    chk("a_done_once", 32'(done_cnt), 32'd1);

    // run B: fresh pointer, four simultaneous edges, then grant/edge collision and drops
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    start_run(16'd0);
    step_to(2);
    fire(4'b1111, 1'b1);
    chk("b_burst_empty", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("b_burst_valid", 32'(evt_valid), 32'd1);
      chk("b_burst_ch", 32'(evt_ch), 32'(k));
      chk("b_burst_time", 32'(evt_time), 32'd2);
    end
    step();
    chk("b_burst_end", 32'(evt_valid), 32'd0);

    evt_ready = 1'b0;
    step_to(20);
    fire(4'b1000, 1'b1);
    step_to(22);
    fire(4'b0010, 1'b1);
    step_to(24);
    evt_ready = 1'b1;
    fire(4'b0010, 1'b1);
    step_to(28);
    chk("b_collide_nodrop", 32'(drop_count), 32'd0);
    chk("b_collide_flushed", 32'(exp_q.size()), 32'd0);

    evt_ready = 1'b0;
    step_to(30);
    fire(4'b0010, 1'b1);
    while (tmr < 42) begin
      if (tmr == 33 || tmr == 36 || tmr == 39) pulse = 4'b0010;
      if (tmr == 33) exp_q.push_back({2'd1, 16'd33});
      if (tmr >= 32) begin
        chk("b_hold_valid", 32'(evt_valid), 32'd1);
        chk("b_hold_ch", 32'(evt_ch), 32'd1);
        chk("b_hold_time", 32'(evt_time), 32'd30);
      end
      step();
      pulse = 4'b0000;
    end
    chk("b_drop_count", 32'(drop_count), 32'(exp_drop));
    evt_ready = 1'b1;
    step_to(46);
    chk("b_drop_after", 32'(drop_count), 32'(exp_drop));
    chk("b_flushed", 32'(exp_q.size()), 32'd0);
    run_stop = 1'b1;
    step();
    run_stop = 1'b0;
    wait_done("b_done", 20);

    // run C: unbounded window, timer wrap, stop with events still pending
    start_run(16'd0);
    chk("c_drop_cleared", 32'(drop_count), 32'd0);
    step_to(65534);
    fire(4'b0001, 1'b1);
    step_to(65536);
    fire(4'b1000, 1'b1);
    step();
    chk("c_wrap_ch", 32'(evt_ch), 32'd3);
    chk("c_wrap_time", 32'(evt_time), 32'd0);
    step_to(70000);
    evt_ready = 1'b0;
    run_stop  = 1'b1;
    fire(4'b0110, 1'b1);
    run_stop  = 1'b0;
    repeat (3) step();
    chk("c_drain_active", 32'(run_active), 32'd1);
    chk("c_drain_nodone", 32'(done), 32'd0);
    chk("c_drain_ch", 32'(evt_ch), 32'd1);
    chk("c_drain_time", 32'(evt_time), 32'd4464);
    evt_ready = 1'b1;
    wait_done("c_done", 20);
    chk("c_flushed", 32'(exp_q.size()), 32'd0);

    // run D: reset with three events queued and output valid
    start_run(16'd0);
    evt_ready = 1'b0;
    step_to(2);
    fire(4'b0111, 1'b1);
    step();
    step();
    chk("d_pre_valid", 32'(evt_valid), 32'd1);
    chk("d_pre_ch", 32'(evt_ch), 32'd0);
    saved_done = done_cnt;
    rst = 1'b1;
    step();
    chk("d_rst_valid", 32'(evt_valid), 32'd0);
    chk("d_rst_ch", 32'(evt_ch), 32'd0);
    chk("d_rst_time", 32'(evt_time), 32'd0);
    chk("d_rst_active", 32'(run_active), 32'd0);
    chk("d_rst_done", 32'(done), 32'd0);
    chk("d_rst_drop", 32'(drop_count), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (3) step();
    chk("d_no_done", 32'(done_cnt), 32'(saved_done));
    chk("d_idle_valid", 32'(evt_valid), 32'd0);

    // run E: normal operation after the mid-run reset
    start_run(16'd20);
    step_to(2);
    fire(4'b1000, 1'b1);
    step();
    chk("e_valid", 32'(evt_valid), 32'd1);
    chk("e_ch", 32'(evt_ch), 32'd3);
    chk("e_time", 32'(evt_time), 32'd2);
    wait_done("e_done", 40);
    chk("e_flushed", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
